instrumented_adder_sequencer: RTL and testbench

Measurement initiator for the instrumented adder. It loads operands, enables the adder ring loop and opens a fixed-length counting window on wb_clk_i. During the window it counts rising edges of the asynchronous chain output. It then delivers the edge count to the logic-analyser readback path over a valid/ready handshake. The adder is the responder; this block drives it and reads its result.

---
 rtl/instrumented_adder_sequencer.sv | 188 ++++++++++++++++++
 tb/tb_instrumented_adder_sequencer.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instrumented_adder_sequencer.sv
// Measurement initiator for the instrumented adder: drives operands, closes the ring,
// counts synchronised rising edges of chain_in over a fixed window and hands the count out.
module instrumented_adder_sequencer #(
    parameter int unsigned WIDTH         = 32,
    parameter int unsigned CNT_W         = 32,
    parameter int unsigned WIN_W         = 16,
    parameter int unsigned SETTLE_CYCLES = 4,
    parameter int unsigned SYNC_STAGES   = 2
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic [WIDTH-1:0] a_operand,
    input  logic [WIDTH-1:0] b_operand,
    input  logic [WIN_W-1:0] window_len,
    input  logic             chain_in,
    output logic [WIDTH-1:0] adder_a,
    output logic [WIDTH-1:0] adder_b,
    output logic             ring_en,
    output logic             busy,
    output logic [CNT_W-1:0] result,
    output logic             result_ovf,
    output logic             result_valid,
    input  logic             result_ready
);

    typedef enum logic [2:0] {IDLE, SETTLE, COUNT, DRAIN, HOLD} state_t;

    state_t                 state_q;
    logic [WIN_W-1:0]       timer_q;
    logic [WIN_W-1:0]       win_len_q;
    logic [WIDTH-1:0]       adder_a_q;
    logic [WIDTH-1:0]       adder_b_q;
    logic                   ring_en_q;
    logic                   busy_q;
    logic                   result_valid_q;
    logic                   result_ovf_q;
    logic [CNT_W-1:0]       result_q;
    logic [CNT_W-1:0]       cnt_q;
    logic [CNT_W-1:0]       cnt_d;
    logic                   cnt_ovf_q;
    logic                   cnt_ovf_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] en_pipe_q;
    logic                   prev_q;
    logic                   rise;
    logic                   count_en;
    logic                   accept;

    assign accept   = (state_q == IDLE) && start && !abort;
    assign rise     = sync_q[SYNC_STAGES-1] && !prev_q;
    assign count_en = rise && en_pipe_q[SYNC_STAGES-1] &&
                      ((state_q == COUNT) || (state_q == DRAIN));

    // en_pipe delays the COUNT window by the synchroniser depth, so exactly the chain
    // samples taken during COUNT are counted, the tail of them emerging during DRAIN.
    always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            sync_q    <= '0;
            prev_q    <= 1'b0;
            en_pipe_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], chain_in};
            prev_q <= sync_q[SYNC_STAGES-1];
            if (abort) begin
                en_pipe_q <= '0;
            end else begin
                en_pipe_q <= {en_pipe_q[SYNC_STAGES-2:0], state_q == COUNT};
            end
        end
    end

    always_comb begin
        cnt_d     = cnt_q;
        cnt_ovf_d = cnt_ovf_q;
        if (accept) begin
            cnt_d     = '0;
            cnt_ovf_d = 1'b0;
        end else if (count_en) begin
            if (&cnt_q) begin
                cnt_ovf_d = 1'b1;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            cnt_q     <= '0;
            cnt_ovf_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            cnt_ovf_q <= cnt_ovf_d;
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            state_q        <= IDLE;
            timer_q        <= '0;
            win_len_q      <= '0;
            adder_a_q      <= '0;
            adder_b_q      <= '0;
            ring_en_q      <= 1'b0;
            busy_q         <= 1'b0;
            result_valid_q <= 1'b0;
            result_ovf_q   <= 1'b0;
            result_q       <= '0;
        end else if (abort && (state_q != IDLE)) begin
            state_q        <= IDLE;
            ring_en_q      <= 1'b0;
            busy_q         <= 1'b0;
            result_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        adder_a_q <= a_operand;
                        adder_b_q <= b_operand;
                        win_len_q <= window_len;
                        ring_en_q <= 1'b1;
                        busy_q    <= 1'b1;
                        timer_q   <= WIN_W'(SETTLE_CYCLES - 1);
                        state_q   <= SETTLE;
                    end
                end
                SETTLE: begin
                    if (timer_q == '0) begin
                        if (win_len_q == '0) begin
                            ring_en_q <= 1'b0;
                            timer_q   <= WIN_W'(SYNC_STAGES - 1);
                            state_q   <= DRAIN;
                        end else begin
                            timer_q <= win_len_q - WIN_W'(1);
                            state_q <= COUNT;
                        end
                    end else begin
                        timer_q <= timer_q - WIN_W'(1);
                    end
                end
                COUNT: begin
                    if (timer_q == '0) begin
                        ring_en_q <= 1'b0;
                        timer_q   <= WIN_W'(SYNC_STAGES - 1);
                        state_q   <= DRAIN;
                    end else begin
                        timer_q <= timer_q - WIN_W'(1);
                    end
                end
                DRAIN: begin
                    if (timer_q == '0) begin
                        state_q <= HOLD;
                    end else begin
                        timer_q <= timer_q - WIN_W'(1);
                    end
                end
                HOLD: begin
                    // First HOLD cycle loads the settled count; the handshake follows.
                    if (!result_valid_q) begin
                        result_q       <= cnt_q;
                        result_ovf_q   <= cnt_ovf_q;
                        result_valid_q <= 1'b1;
                    end else if (result_ready) begin
                        result_valid_q <= 1'b0;
                        busy_q         <= 1'b0;
                        state_q        <= IDLE;
                    end
                end
                default: begin
                    state_q   <= IDLE;
                    ring_en_q <= 1'b0;
                    busy_q    <= 1'b0;
                end
            endcase
        end
    end

    assign adder_a      = adder_a_q;
    assign adder_b      = adder_b_q;
    assign ring_en      = ring_en_q;
    assign busy         = busy_q;
    assign result       = result_q;
    assign result_ovf   = result_ovf_q;
    assign result_valid = result_valid_q;

endmodule

// File: tb/tb_instrumented_adder_sequencer.sv
// Bench for instrumented_adder_sequencer: a default instance and a CNT_W=4 instance share all
// inputs; a timestamp-based model predicts every output each cycle.
module tb_instrumented_adder_sequencer;

    localparam int S  = 4;
    localparam int D  = 2;
    localparam int HN = 8192;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [31:0] a_op = '0;
    logic [31:0] b_op = '0;
    logic [15:0] wlen = '0;
    logic        chain = 1'b0;
    logic        ready = 1'b0;

    logic [31:0] aa, ab, res;
    logic        ring, busy, ovf, vld;
    logic [31:0] aa_s, ab_s;
    logic [3:0]  res_s;
    logic        ring_s, busy_s, ovf_s, vld_s;

    int checks = 0;
    int errors = 0;

    instrumented_adder_sequencer dut (
        .wb_clk_i(clk), .wb_rst_n(rst_n), .start(start), .abort(abort),
        .a_operand(a_op), .b_operand(b_op), .window_len(wlen), .chain_in(chain),
        .adder_a(aa), .adder_b(ab), .ring_en(ring), .busy(busy),
        .result(res), .result_ovf(ovf), .result_valid(vld), .result_ready(ready)
    );

    instrumented_adder_sequencer #(.CNT_W(4)) dut_sat (
        .wb_clk_i(clk), .wb_rst_n(rst_n), .start(start), .abort(abort),
        .a_operand(a_op), .b_operand(b_op), .window_len(wlen), .chain_in(chain),
        .adder_a(aa_s), .adder_b(ab_s), .ring_en(ring_s), .busy(busy_s),
        .result(res_s), .result_ovf(ovf_s), .result_valid(vld_s), .result_ready(ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // chain_in stimulus: square wave of chain_per clocks, changing just after each edge
    int chain_per = 0;
    int chain_ph  = 0;
    initial forever begin
        @(posedge clk);
        #1;
        if (chain_per != 0) begin
            chain_ph = (chain_ph + 1) % chain_per;
            chain    = (chain_ph >= chain_per / 2);
        end
    end

    // Model: one measurement described by its start cycle t0 and window length
    bit          hist [HN];
    int          cyc = 0;
    bit          active = 0;
    int          t0 = 0;
    int          mw = 0;
    logic [31:0] exp_a = '0;
    logic [31:0] exp_b = '0;
    longint      last_edges = 0;

    function automatic int vcyc();
        return t0 + 1 + S + mw + D + 1;
    endfunction

    function automatic longint count_edges(int t, int w);
        longint n = 0;
        for (int c = t + S + 1; c <= t + S + w; c++) begin
            if (!hist[c-1] && hist[c]) n++;
        end
        return n;
    endfunction

    initial forever begin
        @(posedge clk);
        if (cyc < HN) hist[cyc] = chain;
        if (!rst_n) begin
            active     = 0;
            last_edges = 0;
            exp_a      = '0;
            exp_b      = '0;
        end else if (active) begin
            if (abort) active = 0;
            else if (cyc >= vcyc() && ready) active = 0;
        end else if (start && !abort) begin
            active = 1;
            t0     = cyc;
            mw     = int'(wlen);
            exp_a  = a_op;
            exp_b  = b_op;
        end
        if (rst_n && active && (cyc + 1 == vcyc())) last_edges = count_edges(t0, mw);
        cyc++;
    end

    initial forever begin
        logic [31:0] e_a, e_b, e_res;
        logic [3:0]  e_res_s;
        logic        e_ring, e_busy, e_vld, e_ovf, e_ovf_s;
        @(negedge clk);
        if (rst_n !== 1'b1) begin
            e_a = '0; e_b = '0; e_ring = 0; e_busy = 0; e_vld = 0;
            e_res = '0; e_ovf = 0; e_res_s = '0; e_ovf_s = 0;
        end else begin
            e_a     = exp_a;
            e_b     = exp_b;
            e_busy  = active;
            e_ring  = active && (cyc >= t0 + 1) && (cyc <= t0 + S + mw);
            e_vld   = active && (cyc >= vcyc());
            e_ovf   = (last_edges > 64'hFFFF_FFFF);
            e_res   = e_ovf ? 32'hFFFF_FFFF : 32'(last_edges);
            e_ovf_s = (last_edges > 15);
            e_res_s = e_ovf_s ? 4'hF : 4'(last_edges);
        end
        chk("adder_a", aa, e_a);
        chk("adder_b", ab, e_b);
        chk("ring_en", ring, e_ring);
        chk("busy", busy, e_busy);
        chk("result_valid", vld, e_vld);
        chk("result", res, e_res);
        chk("result_ovf", ovf, e_ovf);
        chk("sat.adder_a", aa_s, e_a);
        chk("sat.adder_b", ab_s, e_b);
        chk("sat.ring_en", ring_s, e_ring);
        chk("sat.busy", busy_s, e_busy);
        chk("sat.result_valid", vld_s, e_vld);
        chk("sat.result", res_s, e_res_s);
        chk("sat.result_ovf", ovf_s, e_ovf_s);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [31:0] a, input logic [31:0] b, input logic [15:0] w);
        a_op  = a;
        b_op  = b;
        wlen  = w;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // n = cycles from the start-sampling edge to the first cycle showing result_valid
    task automatic wait_valid(input int limit, output int n);
        n = -1;
        for (int i = 1; i <= limit; i++) begin
            @(negedge clk);
            if (vld === 1'b1) begin
                n = i;
                break;
            end
        end
    endtask

    initial begin
        int n;
        int vcount;

        // reset with chain toggling
        chain_per = 4;
        repeat (6) tick();
        @(negedge clk);
        chk("reset.busy", busy, 1'b0);
        chk("reset.ring_en", ring, 1'b0);
        chk("reset.result_valid", vld, 1'b0);
        tick();
        rst_n = 1'b1;
        repeat (6) tick();
        @(negedge clk);
        chk("post_reset.busy", busy, 1'b0);
        chk("post_reset.result", res, 32'd0);

        // nominal measurement
        ready = 1'b1;
        tick();
        do_start(32'h0000_0010, 32'h0, 16'd100);
        @(negedge clk);
        chk("nominal.adder_a", aa, 32'h10);
        chk("nominal.ring_en", ring, 1'b1);
        wait_valid(200, n);
        chk("nominal.latency", n < 0 ? -1 : n + 1, 108);
        chk("nominal.result", res, 32'd25);
        chk("nominal.ovf", ovf, 1'b0);
        chk("nominal.sat_result", res_s, 4'd15);
        chk("nominal.sat_ovf", ovf_s, 1'b1);
        repeat (3) tick();

        // back-pressure with ignored start pulses
        ready = 1'b0;
        do_start(32'h0000_1234, 32'h0000_5678, 16'd20);
        wait_valid(100, n);
        chk("bp.latency", n, 28);
        for (int i = 0; i < 20; i++) begin
            tick();
            a_op  = $urandom;
            start = (i % 2 == 0);
        end
        start = 1'b0;
        @(negedge clk);
        chk("bp.result", res, 32'd5);
        chk("bp.valid_held", vld, 1'b1);
        chk("bp.adder_a_held", aa, 32'h1234);
        tick();
        ready = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        @(negedge clk);
        chk("bp.busy_after_hs", busy, 1'b0);
        chk("bp.valid_after_hs", vld, 1'b0);
        repeat (3) tick();

        // zero-length window
        chain_per = 2;
        do_start(32'hAAAA_5555, 32'hFFFF_FFFF, 16'd0);
        wait_valid(50, n);
        chk("zero.latency", n, 8);
        chk("zero.result", res, 32'd0);
        chk("zero.ovf", ovf, 1'b0);
        repeat (3) tick();

        // saturation in the CNT_W=4 instance
        do_start(32'h1, 32'h2, 16'd64);
        wait_valid(200, n);
        chk("sat.latency", n, 72);
        chk("sat.result_lit", res_s, 4'd15);
        chk("sat.ovf_lit", ovf_s, 1'b1);
        chk("sat.wide_result", res, 32'd32);
        chk("sat.wide_ovf", ovf, 1'b0);
        repeat (3) tick();

        // abort at window cycle 10, then a clean rerun
        chain_per = 4;
        do_start(32'h3, 32'h4, 16'd100);
        repeat (13) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        @(negedge clk);
        chk("abort.ring_en", ring, 1'b0);
        chk("abort.busy", busy, 1'b0);
        vcount = 0;
        for (int i = 0; i < 150; i++) begin
            @(negedge clk);
            if (vld !== 1'b0) vcount++;
        end
        chk("abort.no_valid", vcount, 0);
        tick();
        do_start(32'h5, 32'h6, 16'd40);
        wait_valid(100, n);
        chk("rerun.latency", n, 48);
        chk("rerun.result", res, 32'd10);
        repeat (3) tick();

        // start and abort together in IDLE
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        @(negedge clk);
        chk("idle_abort.busy", busy, 1'b0);
        repeat (2) tick();

        // abort in HOLD discards the pending result
        ready = 1'b0;
        do_start(32'h7, 32'h8, 16'd8);
        wait_valid(50, n);
        chk("hold_abort.latency", n, 16);
        tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        @(negedge clk);
        chk("hold_abort.valid", vld, 1'b0);
        chk("hold_abort.busy", busy, 1'b0);
        chk("hold_abort.result_kept", res, 32'd2);
        ready = 1'b1;
        repeat (3) tick();

        // reset mid-measurement
        do_start(32'h9, 32'hA, 16'd50);
        repeat (20) tick();
        rst_n = 1'b0;
        @(negedge clk);
        chk("midreset.ring_en", ring, 1'b0);
        chk("midreset.busy", busy, 1'b0);
        chk("midreset.adder_a", aa, 32'h0);
        chk("midreset.result", res, 32'h0);
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (6) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
